// File: rtl/target_port_if.sv
// rtl/target_port_if.sv - serial bus signals between an initiator and target_port
interface target_port_if;
    logic bus_data_in;
    logic bus_data_in_valid;
    logic bus_mode;
    logic bus_init_rw;
    logic bus_init_ready;
    logic split_grant;
    logic bus_data_out;
    logic bus_data_out_valid;
    logic target_ack;
    logic target_split;
    logic split_req;

    modport master (
        output bus_data_in, bus_data_in_valid, bus_mode, bus_init_rw, bus_init_ready, split_grant,
        input  bus_data_out, bus_data_out_valid, target_ack, target_split, split_req
    );

    modport slave (
        input  bus_data_in, bus_data_in_valid, bus_mode, bus_init_rw, bus_init_ready, split_grant,
        output bus_data_out, bus_data_out_valid, target_ack, target_split, split_req
    );
endinterface

// File: rtl/target_port.sv
// rtl/target_port.sv - serial bus target slot with local memory access and split reads
module target_port #(
    parameter logic [3:0]  TARGET_ID     = 4'h1,
    parameter int unsigned SPLIT_TIMEOUT = 4
) (
    input  logic         clk,
    input  logic         rst,
    target_port_if.slave bus,
    input  logic [7:0]   mem_rdata,
    input  logic         mem_rvalid,
    output logic [11:0]  mem_addr,
    output logic [7:0]   mem_wdata,
    output logic         mem_we,
    output logic         mem_re
);
    typedef enum logic [2:0] {IDLE, ADDR, WDATA, READ_WAIT, SPLIT, RESUME, SEND} state_t;

    localparam bit         SPLIT_EN   = (SPLIT_TIMEOUT != 0);
    localparam logic [15:0] SPLIT_LAST = SPLIT_EN ? 16'(SPLIT_TIMEOUT - 1) : 16'd0;

    state_t      state, state_d;
    logic [15:0] addr_sr, addr_sr_d;
    logic [3:0]  addr_cnt, addr_cnt_d;
    logic [7:0]  wdata_sr, wdata_sr_d;
    logic [2:0]  wcnt, wcnt_d;
    logic [7:0]  tx_shift, tx_shift_d;
    logic [3:0]  tx_cnt, tx_cnt_d;
    logic [15:0] wait_cnt, wait_cnt_d;
    logic [11:0] mem_addr_d;
    logic [7:0]  mem_wdata_d;
    logic        mem_we_d, mem_re_d;
    logic        dout_q, dout_d, dout_valid_q, dout_valid_d;
    logic        ack_q, ack_d, split_q, split_d, split_req_q, split_req_d;
    logic        launch;
    logic [7:0]  launch_data;
    logic        addr_bit, data_bit;

    assign addr_bit = bus.bus_data_in_valid && !bus.bus_mode;
    assign data_bit = bus.bus_data_in_valid && bus.bus_mode;

    always_comb begin
        state_d      = state;
        addr_sr_d    = addr_sr;
        addr_cnt_d   = addr_cnt;
        wdata_sr_d   = wdata_sr;
        wcnt_d       = wcnt;
        tx_shift_d   = tx_shift;
        tx_cnt_d     = tx_cnt;
        wait_cnt_d   = wait_cnt;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        ack_d        = 1'b0;
        split_d      = 1'b0;
        split_req_d  = split_req_q;
        launch       = 1'b0;
        launch_data  = 8'd0;

        case (state)
            IDLE, ADDR: begin
                if (addr_bit) begin
                    addr_sr_d[addr_cnt] = bus.bus_data_in;
                    addr_cnt_d          = addr_cnt + 4'd1;
                    state_d             = ADDR;
                    if (addr_cnt == 4'd15) begin
                        // rw is only meaningful alongside the final address bit
                        addr_cnt_d = 4'd0;
                        if (addr_sr_d[15:12] != TARGET_ID) begin
                            state_d = IDLE;
                        end else if (bus.bus_init_rw) begin
                            wcnt_d  = 3'd0;
                            state_d = WDATA;
                        end else begin
                            mem_re_d   = 1'b1;
                            mem_addr_d = addr_sr_d[11:0];
                            wait_cnt_d = 16'd0;
                            state_d    = READ_WAIT;
                        end
                    end
                end
            end
            WDATA: begin
                if (addr_bit) begin
                    // a new address bit abandons the write and restarts reception
                    addr_sr_d[0] = bus.bus_data_in;
                    addr_cnt_d   = 4'd1;
                    wcnt_d       = 3'd0;
                    state_d      = ADDR;
                end else if (data_bit) begin
                    wdata_sr_d[wcnt] = bus.bus_data_in;
                    wcnt_d           = wcnt + 3'd1;
                    if (wcnt == 3'd7) begin
                        mem_we_d    = 1'b1;
                        ack_d       = 1'b1;
                        mem_addr_d  = addr_sr[11:0];
                        mem_wdata_d = wdata_sr_d;
                        state_d     = IDLE;
                    end
                end
            end
            READ_WAIT: begin
                if (mem_rvalid) begin
                    launch      = 1'b1;
                    launch_data = mem_rdata;
                end else if (SPLIT_EN && wait_cnt == SPLIT_LAST) begin
                    split_d = 1'b1;
                    state_d = SPLIT;
                end else begin
                    wait_cnt_d = wait_cnt + 16'd1;
                end
            end
            SPLIT: begin
                if (mem_rvalid) begin
                    tx_shift_d  = mem_rdata;
                    split_req_d = 1'b1;
                    state_d     = RESUME;
                end
            end
            RESUME: begin
                if (bus.split_grant) begin
                    split_req_d = 1'b0;
                    launch      = 1'b1;
                    launch_data = tx_shift;
                end
            end
            SEND: begin
                if (tx_cnt == 4'd8) begin
                    ack_d    = 1'b1;
                    dout_d   = 1'b0;
                    tx_cnt_d = 4'd0;
                    state_d  = IDLE;
                end else if (bus.bus_init_ready) begin
                    dout_d       = tx_shift[tx_cnt[2:0]];
                    dout_valid_d = 1'b1;
                    tx_cnt_d     = tx_cnt + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // bit 0 goes out on the same edge that makes the data available
        if (launch) begin
            tx_shift_d = launch_data;
            state_d    = SEND;
            if (bus.bus_init_ready) begin
                dout_d       = launch_data[0];
                dout_valid_d = 1'b1;
                tx_cnt_d     = 4'd1;
            end else begin
                tx_cnt_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            addr_sr      <= 16'd0;
            addr_cnt     <= 4'd0;
            wdata_sr     <= 8'd0;
            wcnt         <= 3'd0;
            tx_shift     <= 8'd0;
            tx_cnt       <= 4'd0;
            wait_cnt     <= 16'd0;
            mem_addr     <= 12'd0;
            mem_wdata    <= 8'd0;
            mem_we       <= 1'b0;
            mem_re       <= 1'b0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            ack_q        <= 1'b0;
            split_q      <= 1'b0;
            split_req_q  <= 1'b0;
        end else begin
            state        <= state_d;
            addr_sr      <= addr_sr_d;
            addr_cnt     <= addr_cnt_d;
            wdata_sr     <= wdata_sr_d;
            wcnt         <= wcnt_d;
            tx_shift     <= tx_shift_d;
            tx_cnt       <= tx_cnt_d;
            wait_cnt     <= wait_cnt_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            mem_we       <= mem_we_d;
            mem_re       <= mem_re_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            ack_q        <= ack_d;
            split_q      <= split_d;
            split_req_q  <= split_req_d;
        end
    end

    assign bus.bus_data_out       = dout_q;
    assign bus.bus_data_out_valid = dout_valid_q;
    assign bus.target_ack         = ack_q;
    assign bus.target_split       = split_q;
    assign bus.split_req          = split_req_q;
endmodule

// File: tb/tb_target_port.sv
// tb/tb_target_port.sv - self-checking bench for target_port
module tb_target_port;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;

    target_port_if bus ();

    target_port #(.TARGET_ID(4'h1), .SPLIT_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_edge = 0;

    int          we_cyc[$];
    logic [11:0] we_addr[$];
    logic [7:0]  we_data[$];
    int          re_cyc[$];
    logic [11:0] re_addr[$];
    int          ack_cyc[$];
    int          split_cyc[$];
    int          bit_cyc[$];
    logic        bit_val[$];
    int          sreq_rise;
    int          sreq_fall;
    logic        prev_sreq = 1'b0;

    task automatic clear_logs();
        we_cyc.delete(); we_addr.delete(); we_data.delete();
        re_cyc.delete(); re_addr.delete(); ack_cyc.delete(); split_cyc.delete();
        bit_cyc.delete(); bit_val.delete();
        sreq_rise = -1;
        sreq_fall = -1;
    endtask

    // one clock; outputs recorded 1 time unit after the edge that produced them
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_we) begin we_cyc.push_back(cyc); we_addr.push_back(mem_addr); we_data.push_back(mem_wdata); end
        if (mem_re) begin re_cyc.push_back(cyc); re_addr.push_back(mem_addr); end
        if (bus.target_ack) ack_cyc.push_back(cyc);
        if (bus.target_split) split_cyc.push_back(cyc);
        if (bus.bus_data_out_valid) begin bit_cyc.push_back(cyc); bit_val.push_back(bus.bus_data_out); end
        if (bus.split_req && !prev_sreq) sreq_rise = cyc;
        if (!bus.split_req && prev_sreq) sreq_fall = cyc;
        prev_sreq = bus.split_req;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_addr(input logic [15:0] a, input logic rw);
        for (int i = 0; i < 16; i++) begin
            bus.bus_data_in_valid = 1'b1;
            bus.bus_mode          = 1'b0;
            bus.bus_data_in       = a[i];
            bus.bus_init_rw       = (i == 15) ? rw : ~rw;
            tick();
        end
        bus.bus_data_in_valid = 1'b0;
        bus.bus_data_in       = 1'b0;
        last_edge = cyc;
    endtask

    task automatic send_bits(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            bus.bus_data_in_valid = 1'b1;
            bus.bus_mode          = 1'b1;
            bus.bus_data_in       = d[i];
            tick();
        end
        bus.bus_data_in_valid = 1'b0;
        bus.bus_mode          = 1'b0;
        bus.bus_data_in       = 1'b0;
        last_edge = cyc;
    endtask

    // memory answers d edges after the mem_re edge; grant comes gd edges after split_req rises
    task automatic run_read(input logic [7:0] rd, input int d, input int gd, input int stall_after,
                            input int stall_len, input int stop_bits, output logic done);
        int c;
        int stalled;
        c = last_edge;
        stalled = 0;
        done = 1'b0;
        for (int b = 0; b < 300 && !done; b++) begin
            mem_rvalid = (cyc + 1 == c + d);
            mem_rdata  = mem_rvalid ? rd : 8'($urandom);
            bus.split_grant = (sreq_rise >= 0) && (cyc + 1 == sreq_rise + gd);
            if (stall_len > 0 && bit_val.size() >= stall_after && stalled < stall_len) begin
                bus.bus_init_ready = 1'b0;
                stalled++;
            end else begin
                bus.bus_init_ready = 1'b1;
            end
            tick();
            if (ack_cyc.size() > 0) done = 1'b1;
            if (stop_bits >= 0 && bit_val.size() >= stop_bits) done = 1'b1;
        end
        mem_rvalid = 1'b0;
        bus.split_grant = 1'b0;
        bus.bus_init_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        checks++; if ({bus.bus_data_out, bus.bus_data_out_valid, bus.target_ack, bus.target_split, bus.split_req} !== 5'b0) begin
            failures++; $display("FAIL reset_bus_outs: got %b expected 00000", {bus.bus_data_out, bus.bus_data_out_valid, bus.target_ack, bus.target_split, bus.split_req}); end
        checks++; if ({mem_addr, mem_wdata, mem_we, mem_re} !== 22'd0) begin
            failures++; $display("FAIL reset_mem_outs: got %h expected 0", {mem_addr, mem_wdata, mem_we, mem_re}); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_write();
        clear_logs();
        send_addr(16'h1234, 1'b1);
        send_bits(8'hA5, 8);
        idle(3);
        checks++; if (we_cyc.size() !== 1) begin failures++; $display("FAIL wr_we_count: got %0d expected 1", we_cyc.size()); end
        if (we_cyc.size() > 0) begin
            checks++; if (we_addr[0] !== 12'h234) begin failures++; $display("FAIL wr_addr: got %h expected 234", we_addr[0]); end
            checks++; if (we_data[0] !== 8'hA5) begin failures++; $display("FAIL wr_data: got %h expected a5", we_data[0]); end
            checks++; if (we_cyc[0] !== last_edge) begin failures++; $display("FAIL wr_timing: got %0d expected %0d", we_cyc[0], last_edge); end
        end
        checks++; if (ack_cyc.size() !== 1 || (ack_cyc.size() > 0 && ack_cyc[0] !== last_edge)) begin
            failures++; $display("FAIL wr_ack: got count %0d expected ack with we at %0d", ack_cyc.size(), last_edge); end
        checks++; if (re_cyc.size() !== 0) begin failures++; $display("FAIL wr_no_re: got %0d expected 0", re_cyc.size()); end
    endtask

    task automatic test_mismatch();
        clear_logs();
        send_addr(16'h5234, 1'b1);
        send_bits(8'hFF, 8);
        idle(3);
        checks++; if (we_cyc.size() + ack_cyc.size() + re_cyc.size() + bit_val.size() + split_cyc.size() !== 0) begin
            failures++; $display("FAIL mismatch_quiet: got %0d events expected 0", we_cyc.size() + ack_cyc.size() + re_cyc.size() + bit_val.size() + split_cyc.size()); end
        // the next transaction must start cleanly from IDLE
        clear_logs();
        send_addr(16'h1F0F, 1'b1);
        send_bits(8'h3D, 8);
        idle(2);
        checks++; if (we_cyc.size() !== 1 || (we_cyc.size() > 0 && {we_addr[0], we_data[0]} !== {12'hF0F, 8'h3D})) begin
            failures++; $display("FAIL mismatch_then_write: got count %0d expected one write f0f/3d", we_cyc.size()); end
    endtask

    task automatic check_read(input string nm, input logic [11:0] a, input logic [7:0] rd, input int c, input int launch_edge,
                              input int stall_after, input int stall_len, input logic done);
        int exp_c;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL %s_timeout: got no ack expected ack", nm); end
        checks++; if (re_cyc.size() !== 1 || (re_cyc.size() > 0 && (re_cyc[0] !== c || re_addr[0] !== a))) begin
            failures++; $display("FAIL %s_re: got count %0d expected one mem_re at %0d addr %h", nm, re_cyc.size(), c, a); end
        checks++; if (bit_val.size() !== 8) begin failures++; $display("FAIL %s_bitcount: got %0d expected 8", nm, bit_val.size()); end
        for (int i = 0; i < 8 && i < bit_val.size(); i++) begin
            exp_c = launch_edge + i + ((stall_len > 0 && i >= stall_after) ? stall_len : 0);
            checks++; if (bit_val[i] !== rd[i] || bit_cyc[i] !== exp_c) begin
                failures++; $display("FAIL %s_bit%0d: got %b@%0d expected %b@%0d", nm, i, bit_val[i], bit_cyc[i], rd[i], exp_c); end
        end
        exp_c = launch_edge + 8 + stall_len;
        checks++; if (ack_cyc.size() !== 1 || (ack_cyc.size() > 0 && ack_cyc[0] !== exp_c)) begin
            failures++; $display("FAIL %s_ack: got count %0d expected one ack at %0d", nm, ack_cyc.size(), exp_c); end
        checks++; if (we_cyc.size() !== 0) begin failures++; $display("FAIL %s_no_we: got %0d expected 0", nm, we_cyc.size()); end
    endtask

    task automatic test_read_fast();
        int exp_seq[8] = '{0, 0, 1, 1, 1, 1, 0, 0};
        logic done;
        int c;
        clear_logs();
        send_addr(16'h1010, 1'b0);
        c = last_edge;
        run_read(8'h3C, 2, 1, 1, 0, -1, done);
        check_read("fast", 12'h010, 8'h3C, c, c + 2, 1, 0, done);
        for (int i = 0; i < 8 && i < bit_val.size(); i++) begin
            checks++; if (int'(bit_val[i]) !== exp_seq[i]) begin failures++; $display("FAIL fast_seq%0d: got %b expected %0d", i, bit_val[i], exp_seq[i]); end
        end
        checks++; if (split_cyc.size() !== 0) begin failures++; $display("FAIL fast_no_split: got %0d expected 0", split_cyc.size()); end
    endtask

    task automatic test_backpressure();
        logic done;
        int c;
        clear_logs();
        send_addr(16'h1010, 1'b0);
        c = last_edge;
        run_read(8'h3C, 2, 1, 3, 3, -1, done);
        check_read("bp", 12'h010, 8'h3C, c, c + 2, 3, 3, done);
        if (bit_cyc.size() >= 4) begin
            checks++; if (bit_cyc[3] - bit_cyc[2] !== 4) begin failures++; $display("FAIL bp_gap: got %0d expected 4", bit_cyc[3] - bit_cyc[2]); end
        end
    endtask

    task automatic test_split();
        logic done;
        int c;
        clear_logs();
        send_addr(16'h1ABC, 1'b0);
        c = last_edge;
        run_read(8'h81, 10, 3, 1, 0, -1, done);
        checks++; if (split_cyc.size() !== 1 || (split_cyc.size() > 0 && split_cyc[0] !== c + T)) begin
            failures++; $display("FAIL split_pulse: got count %0d expected one pulse at %0d", split_cyc.size(), c + T); end
        checks++; if (sreq_rise !== c + 10) begin failures++; $display("FAIL split_req_rise: got %0d expected %0d", sreq_rise, c + 10); end
        checks++; if (sreq_fall !== c + 13) begin failures++; $display("FAIL split_req_fall: got %0d expected %0d", sreq_fall, c + 13); end
        check_read("split", 12'hABC, 8'h81, c, c + 13, 1, 0, done);
    endtask

    task automatic test_split_race();
        logic done;
        int c;
        clear_logs();
        send_addr(16'h1777, 1'b0);
        c = last_edge;
        run_read(8'h5A, T, 1, 1, 0, -1, done);
        checks++; if (split_cyc.size() !== 0 || sreq_rise !== -1) begin
            failures++; $display("FAIL race_no_split: got %0d pulses expected 0", split_cyc.size()); end
        check_read("race", 12'h777, 8'h5A, c, c + T, 1, 0, done);
    endtask

    task automatic test_abort();
        clear_logs();
        send_addr(16'h1ABC, 1'b1);
        send_bits(8'hC6, 4);
        send_addr(16'h1077, 1'b1);
        send_bits(8'h5E, 8);
        idle(2);
        checks++; if (we_cyc.size() !== 1 || (we_cyc.size() > 0 && {we_addr[0], we_data[0]} !== {12'h077, 8'h5E})) begin
            failures++; $display("FAIL abort_write: got count %0d expected single write 077/5e", we_cyc.size()); end
        checks++; if (ack_cyc.size() !== 1) begin failures++; $display("FAIL abort_ack: got %0d expected 1", ack_cyc.size()); end
    endtask

    task automatic test_reset_send();
        logic done;
        clear_logs();
        send_addr(16'h1333, 1'b0);
        run_read(8'hE7, 2, 1, 1, 0, 3, done);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({bus.bus_data_out, bus.bus_data_out_valid, bus.target_ack, bus.target_split, bus.split_req, mem_we, mem_re} !== 7'b0) begin
            failures++; $display("FAIL rst_send_outs: got %b expected 0000000", {bus.bus_data_out, bus.bus_data_out_valid, bus.target_ack, bus.target_split, bus.split_req, mem_we, mem_re}); end
        checks++; if ({mem_addr, mem_wdata} !== 20'd0) begin failures++; $display("FAIL rst_send_mem: got %h expected 0", {mem_addr, mem_wdata}); end
        clear_logs();
        idle(12);
        checks++; if (bit_val.size() + ack_cyc.size() !== 0) begin
            failures++; $display("FAIL rst_send_quiet: got %0d events expected 0", bit_val.size() + ack_cyc.size()); end
    endtask

    task automatic test_back_to_back();
        logic done;
        int c;
        clear_logs();
        send_addr(16'h1456, 1'b1);
        send_bits(8'hC3, 8);
        send_addr(16'h1789, 1'b0);
        c = last_edge;
        checks++; if (we_cyc.size() !== 1 || (we_cyc.size() > 0 && {we_addr[0], we_data[0]} !== {12'h456, 8'hC3})) begin
            failures++; $display("FAIL b2b_write: got count %0d expected write 456/c3", we_cyc.size()); end
        ack_cyc.delete();
        run_read(8'h9A, 3, 1, 1, 0, -1, done);
        we_cyc.delete();
        check_read("b2b", 12'h789, 8'h9A, c, c + 3, 1, 0, done);
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [7:0]  wd, rd;
        logic        rw, match, done, exp_split;
        int d, gd, sa, sl, c, e, launch_edge;
        for (int n = 0; n < 20; n++) begin
            match = ($urandom_range(0, 3) != 0);
            a     = {match ? 4'h1 : 4'($urandom_range(2, 15)), 12'($urandom)};
            rw    = 1'($urandom_range(0, 1));
            wd    = 8'($urandom);
            rd    = 8'($urandom);
            d     = $urandom_range(1, 12);
            gd    = $urandom_range(1, 5);
            sa    = $urandom_range(1, 7);
            sl    = $urandom_range(0, 3);
            clear_logs();
            send_addr(a, rw);
            c = last_edge;
            if (match && !rw) begin
                run_read(rd, d, gd, sa, sl, -1, done);
                exp_split = (d > T);
                launch_edge = exp_split ? c + d + gd : c + d;
                checks++; if (split_cyc.size() !== int'(exp_split) || (exp_split && split_cyc.size() > 0 && split_cyc[0] !== c + T)) begin
                    failures++; $display("FAIL rnd%0d_split: got %0d pulses expected %0d at %0d", n, split_cyc.size(), exp_split, c + T); end
                check_read("rnd", a[11:0], rd, c, launch_edge, sa, sl, done);
            end else begin
                if (rw) send_bits(wd, 8);
                e = last_edge;
                idle(3);
                if (match) begin
                    checks++; if (we_cyc.size() !== 1 || (we_cyc.size() > 0 && {we_cyc[0], we_addr[0], we_data[0]} !== {e, a[11:0], wd})) begin
                        failures++; $display("FAIL rnd%0d_write: got count %0d expected write %h/%h at %0d", n, we_cyc.size(), a[11:0], wd, e); end
                    checks++; if (ack_cyc.size() !== 1) begin failures++; $display("FAIL rnd%0d_wack: got %0d expected 1", n, ack_cyc.size()); end
                end else begin
                    checks++; if (we_cyc.size() + ack_cyc.size() + re_cyc.size() + split_cyc.size() !== 0) begin
                        failures++; $display("FAIL rnd%0d_mismatch: got %0d events expected 0", n, we_cyc.size() + ack_cyc.size() + re_cyc.size() + split_cyc.size()); end
                end
            end
            idle($urandom_range(0, 2));
        end
    endtask

    initial begin
        rst = 1'b1;
        mem_rdata = 8'd0;
        mem_rvalid = 1'b0;
        bus.bus_data_in = 1'b0;
        bus.bus_data_in_valid = 1'b0;
        bus.bus_mode = 1'b0;
        bus.bus_init_rw = 1'b0;
        bus.bus_init_ready = 1'b1;
        bus.split_grant = 1'b0;
        test_reset();
        test_write();
        test_mismatch();
        test_read_fast();
        test_backpressure();
        test_split();
        test_split_race();
        test_abort();
        test_reset_send();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/target_port.md
# target_port

Serial-bus responder that terminates one target slot on the shared serial bus. It deserialises the 16-bit address and 8-bit write data that an initiator shifts out LSB-first, and decodes the target select field. It performs a single-beat access on a simple local memory interface, then returns read data serially. Slow reads can be split: the target releases the bus and later requests it back to deliver the data.

## Interface
- TARGET_ID, 4'h1, value matched against address bits [15:12]
- SPLIT_TIMEOUT, 4, cycles in READ_WAIT before splitting; 0 disables split
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- bus_data_in  input  1  serial bit from initiator
- bus_data_in_valid  input  1  bus_data_in qualifier, one bit per cycle
- bus_mode  input  1  1 = data bit, 0 = address bit
- bus_init_rw  input  1  1 = write, 0 = read; sampled with the 16th address bit
- bus_init_ready  input  1  initiator can accept read data
- split_grant  input  1  arbiter grants bus back for split completion
- mem_rdata  input  8  local read data
- mem_rvalid  input  1  mem_rdata qualifier, single-cycle pulse
- bus_data_out  output  1  serial read-data bit
- bus_data_out_valid  output  1  bus_data_out qualifier
- target_ack  output  1  one-cycle transfer-complete pulse
- target_split  output  1  one-cycle split notification pulse
- split_req  output  1  level request to resume a split read
- mem_addr  output  12  local address (bus address [11:0])
- mem_wdata  output  8  local write data
- mem_we  output  1  one-cycle write strobe
- mem_re  output  1  one-cycle read strobe

## Operation
- All outputs are registered and reset to 0. The FSM resets to IDLE, and the bit counters and shift registers reset to 0.
- FSM states: IDLE, ADDR, WDATA, READ_WAIT, SPLIT, RESUME, SEND.
- **IDLE/ADDR:** each bus_data_in_valid with bus_mode=0 stores the bit at position addr_cnt (4-bit, 0..15, LSB-first).
  - The first such bit moves IDLE to ADDR.
  - On bit 15, the module latches bus_init_rw and compares addr[15:12] with TARGET_ID.
  - Mismatch: return to IDLE with no output activity.
  - Match + write: go to WDATA. Match + read: pulse mem_re, drive mem_addr, go to READ_WAIT.
- IDLE ignores valid bits with bus_mode=1.
- **WDATA:** collects 8 bits with bus_mode=1, LSB-first (3-bit counter).
  - After bit 7: pulse mem_we and target_ack together, holding mem_addr and mem_wdata stable. Then return to IDLE.
  - A valid bus_mode=0 bit arriving in WDATA aborts the write with no mem_we. That bit becomes address bit 0 and the FSM goes to ADDR.
- **READ_WAIT:** counts cycles from entry.
  - mem_rvalid: latch mem_rdata into tx_shift, go to SEND.
  - Count reaches SPLIT_TIMEOUT (nonzero) with no mem_rvalid: pulse target_split, go to SPLIT.
  - If mem_rvalid and the timeout land in the same cycle, mem_rvalid wins and no split occurs.
- **SPLIT:** waits for mem_rvalid and latches the data. It then raises split_req and goes to RESUME.
- **RESUME:** holds split_req high until split_grant is sampled high. It then drops split_req and goes to SEND.
- **SEND:** while bus_init_ready=1, shifts out one bit per cycle LSB-first with bus_data_out_valid=1.
  - bus_init_ready=0 stalls the transfer. valid drops, and bus_data_out and the bit count hold.
  - The cycle after the 8th bit, target_ack pulses and the FSM returns to IDLE.
- From READ_WAIT through SEND, all bus input bits are ignored.
- Synchronous rst in any state aborts at the next edge. A pending mem_we, ack or split is not issued, and split_req drops.

## Timing
- Edge N samples address bit 15 (read): mem_re=1 in cycle N+1, mem_addr valid from N+1.
- Edge N samples write-data bit 7: mem_we=1 and target_ack=1 in cycle N+1.
- Edge M samples mem_rvalid (READ_WAIT), with bus_init_ready=1: bit 0 appears in cycle M+1, bit 7 in M+8, and target_ack in M+9.
- Split: entry to READ_WAIT at cycle E, with no rvalid. target_split=1 in cycle E+SPLIT_TIMEOUT.
- split_req rises the cycle after mem_rvalid is sampled in SPLIT. split_grant sampled at edge G gives split_req=0 and bit 0 in cycle G+1.
- Minimum spacing between transactions: a new address bit may be accepted the cycle after target_ack.

## Test plan
- Write to matching target: TARGET_ID=1, address 16'h1234 LSB-first with rw=1, then data 8'hA5 -> one cycle with mem_we=1, mem_addr=12'h234, mem_wdata=8'hA5, target_ack=1.
- Address mismatch: address 16'h5234, rw=1, data 8'hFF -> no mem_we, no ack, FSM back in IDLE.
- Read, fast memory: address 16'h1010, rw=0, mem_rvalid with 8'h3C two cycles after mem_re -> bus_data_out sequence 0,0,1,1,1,1,0,0, then target_ack, and no target_split.
- Backpressure: same read with bus_init_ready low for 3 cycles after bit 2 -> valid gap of 3 cycles, bits intact, 8 valid bits total.
- Split: SPLIT_TIMEOUT=4, mem_rvalid 10 cycles after mem_re with 8'h81 -> target_split pulse 4 cycles after entering READ_WAIT, then split_req high. split_grant given 3 cycles later -> serial 1,0,0,0,0,0,0,1, then ack.
- Abort and reset: a bus_mode=0 bit during WDATA restarts address reception with no mem_we. rst asserted mid-SEND -> all outputs 0 next cycle and FSM in IDLE.
